beat_ram_sequencer: RTL and testbench

Sequences the beat-recording RAM for the recorder/playback modes. In record mode it samples the current keyboard note code at a fixed tick rate and writes it to consecutive RAM addresses. In playback mode it reads the stored codes back at the same rate and loops over the recorded length. It sits between the mode FSM (which drives `rec_en` and `play_en`) and the on-chip single-port RAM.

---
 rtl/beat_pkg.sv | 12 +
 rtl/tick_gen.sv | 30 +++
 rtl/beat_ram_sequencer.sv | 138 +++++++++++++
 tb/tb_beat_ram_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared state encodings and default widths for the beat recorder
package beat_pkg;

  // Encodings double as the HEX0 mode codes shown to the user.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REC  = 2'b01;
  localparam logic [1:0] ST_PLAY = 2'b11;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - clears-on-request divider producing a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires one cycle ahead of the registered strobes it launches.
  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/beat_ram_sequencer.sv
// rtl/beat_ram_sequencer.sv - records key codes into RAM at the tick rate and loops them back in playback
module beat_ram_sequencer
  import beat_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 100,
  parameter int TICK_DIV = CLK_HZ / TICK_HZ,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              rec_en,
  input  logic              play_en,
  input  logic [DATA_W-1:0] key_code,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  output logic [DATA_W-1:0] play_code,
  output logic              play_valid,
  output logic [ADDR_W:0]   rec_len,
  output logic              full,
  output logic [1:0]        state
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(DEPTH - 1);

  logic [1:0] state_next;
  logic       rec_armed;
  logic       tick;
  logic       wr_fire;
  logic       rd_fire;
  logic       rec_start;
  logic       play_start;
  logic       play_stop;
  logic       full_stop;
  logic       play_wrap;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .en    (state != ST_IDLE),
    .clr   (state_next != state),
    .tick  (tick)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rec_en && rec_armed) begin
          state_next = ST_REC;
        end else if (play_en && !rec_en && rec_len != '0) begin
          state_next = ST_PLAY;
        end
      end
      ST_REC: begin
        if (!rec_en || full_stop) begin
          state_next = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (!play_en) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_fire    = (state == ST_REC) && rec_en && tick;
    rd_fire    = (state == ST_PLAY) && play_en && tick;
    rec_start  = (state == ST_IDLE) && (state_next == ST_REC);
    play_start = (state == ST_IDLE) && (state_next == ST_PLAY);
    play_stop  = (state == ST_PLAY) && (state_next == ST_IDLE);
    // The write in flight during this cycle is the one that fills the RAM.
    full_stop  = ram_wren && (rec_len == LEN_LAST);
    play_wrap  = ({1'b0, ram_addr} == rec_len - 1'b1);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wren   <= 1'b0;
      play_code  <= '0;
      play_valid <= 1'b0;
      rec_len    <= '0;
      full       <= 1'b0;
      rec_armed  <= 1'b1;
    end else begin
      ram_wren   <= wr_fire;
      play_valid <= rd_fire;
      if (wr_fire) begin
        ram_wdata <= key_code;
      end
      if (rd_fire) begin
        play_code <= ram_rdata;
      end else if (play_stop) begin
        play_code <= '0;
      end
      // Address moves on the edge closing each strobe cycle, so the strobe sees the current slot.
      if (rec_start) begin
        ram_addr <= '0;
        rec_len  <= '0;
        full     <= 1'b0;
      end else if (play_start) begin
        ram_addr <= '0;
      end else if (ram_wren) begin
        ram_addr <= ram_addr + 1'b1;
        rec_len  <= rec_len + 1'b1;
      end else if (play_valid) begin
        ram_addr <= play_wrap ? '0 : ram_addr + 1'b1;
      end
      if (full_stop) begin
        full      <= 1'b1;
        rec_armed <= 1'b0;
      end else if (state == ST_IDLE && !rec_en) begin
        rec_armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_beat_ram_sequencer.sv
// tb/tb_beat_ram_sequencer.sv - directed/randomized self-checking bench for beat_ram_sequencer
module tb_beat_ram_sequencer;

  localparam int TD    = 4;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rec_en = 1'b0;
  logic          play_en = 1'b0;
  logic [DW-1:0] key_code = '0;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] play_code;
  logic          play_valid;
  logic [AW:0]   rec_len;
  logic          full;
  logic [1:0]    state;

  always #5 clk = ~clk;

  beat_ram_sequencer #(
    .TICK_DIV (TD),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .rec_en     (rec_en),
    .play_en    (play_en),
    .key_code   (key_code),
    .ram_rdata  (ram_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wren   (ram_wren),
    .play_code  (play_code),
    .play_valid (play_valid),
    .rec_len    (rec_len),
    .full       (full),
    .state      (state)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int            cyc = 0;
  int            wr_cyc[$];
  int            wr_addr[$];
  int            wr_data[$];
  int            pv_cyc[$];
  int            pv_code[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (resetn) begin
      if (ram_wren) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(ram_addr));
        wr_data.push_back(int'(ram_wdata));
      end
      if (play_valid) begin
        pv_cyc.push_back(cyc);
        pv_code.push_back(int'(play_code));
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int exp_data[$];
  int model_mem[DEPTH];
  int model_len = 0;
  int entry;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    pv_cyc.delete(); pv_code.delete(); exp_data.delete();
  endtask

  // Waits for n writes, presenting a fresh key code after each one is seen.
  task automatic collect_writes(input int n, input bit fixed);
    int waited;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      exp_data.push_back(int'(key_code));
      while (wr_cyc.size() <= i && waited < 3 * TD) begin
        @(negedge clk);
        waited++;
      end
      check("wr_seen", 32'(wr_cyc.size() > i), 1);
      key_code = fixed ? 8'(8'h11 * (i + 2)) : 8'($urandom_range(1, 255));
    end
  endtask

  task automatic verify_writes(input int ent, input int n);
    check("wr_count", wr_cyc.size(), n);
    for (int i = 0; i < n && i < wr_cyc.size(); i++) begin
      check("wr_cycle", wr_cyc[i] - ent, TD * (i + 1));
      check("wr_addr", wr_addr[i], i % DEPTH);
      check("wr_data", wr_data[i], exp_data[i]);
      model_mem[i % DEPTH] = exp_data[i];
    end
    model_len = n;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_wdata"}, ram_wdata, 0);
    check({tag, "_wren"}, ram_wren, 0);
    check({tag, "_pcode"}, play_code, 0);
    check({tag, "_pvalid"}, play_valid, 0);
    check({tag, "_len"}, rec_len, 0);
    check({tag, "_full"}, full, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    check("idle_after_reset", state, 2'b00);

    // Record three fixed codes, then drop rec_en in the third write cycle.
    clear_logs();
    key_code = 8'h11;
    rec_en = 1'b1;
    entry = cyc + 1;
    collect_writes(3, 1'b1);
    rec_en = 1'b0;
    repeat (TD + 2) @(negedge clk);
    verify_writes(entry, 3);
    check("t1_len", rec_len, 3);
    check("t1_state", state, 2'b00);

    // Playback loops over the recorded length.
    clear_logs();
    play_en = 1'b1;
    entry = cyc + 1;
    @(negedge clk);
    check("t2_state", state, 2'b11);
    waited = 0;
    while (pv_cyc.size() < 4 && waited < 6 * TD) begin
      @(negedge clk);
      waited++;
    end
    play_en = 1'b0;
    @(negedge clk);
    check("t2_pv_count", pv_cyc.size(), 4);
    for (int i = 0; i < 4 && i < pv_cyc.size(); i++) begin
      check("t2_pv_cycle", pv_cyc[i] - entry, TD * (i + 1));
      check("t2_pv_code", pv_code[i], model_mem[i % model_len]);
    end
    check("t2_code_cleared", play_code, 0);
    check("t2_state_idle", state, 2'b00);

    // Fill the RAM while holding rec_en for nine tick periods.
    clear_logs();
    key_code = 8'($urandom_range(1, 255));
    rec_en = 1'b1;
    entry = cyc + 1;
    collect_writes(DEPTH, 1'b0);
    while (cyc < entry + 9 * TD) @(negedge clk);
    verify_writes(entry, DEPTH);
    check("t3_full", full, 1);
    check("t3_len", rec_len, DEPTH);
    check("t3_state", state, 2'b00);
    repeat (TD) @(negedge clk);
    check("t3_no_reentry", state, 2'b00);
    check("t3_no_extra_wr", wr_cyc.size(), DEPTH);
    rec_en = 1'b0;
    @(negedge clk);
    rec_en = 1'b1;
    @(negedge clk);
    check("t3_rearm", state, 2'b01);
    check("t3_full_cleared", full, 0);
    check("t3_len_cleared", rec_len, 0);
    rec_en = 1'b0;
    @(negedge clk);
    check("t3_back_idle", state, 2'b00);

    // rec_en wins over play_en; empty playback stays idle.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rec_en = 1'b1;
    play_en = 1'b1;
    @(negedge clk);
    check("t4_priority", state, 2'b01);
    rec_en = 1'b0;
    play_en = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    clear_logs();
    play_en = 1'b1;
    repeat (2 * TD + 1) @(negedge clk);
    check("t4_empty_play", state, 2'b00);
    check("t4_no_pv", pv_cyc.size(), 0);
    play_en = 1'b0;

    // Asynchronous reset in the middle of playback.
    clear_logs();
    key_code = 8'($urandom_range(1, 255));
    rec_en = 1'b1;
    entry = cyc + 1;
    collect_writes(2, 1'b0);
    rec_en = 1'b0;
    repeat (2) @(negedge clk);
    verify_writes(entry, 2);
    pv_cyc.delete(); pv_code.delete();
    play_en = 1'b1;
    waited = 0;
    while (pv_cyc.size() < 1 && waited < 3 * TD) begin
      @(negedge clk);
      waited++;
    end
    check("t5_pv_seen", 32'(pv_cyc.size() >= 1), 1);
    if (pv_code.size() > 0) check("t5_pv_code", pv_code[0], model_mem[0]);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("t5_async");
    @(negedge clk);
    play_en = 1'b0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_state", state, 2'b00);
    check("t5_len", rec_len, 0);

    // Abort two cycles after a write: no partial write.
    clear_logs();
    key_code = 8'($urandom_range(1, 255));
    rec_en = 1'b1;
    entry = cyc + 1;
    collect_writes(2, 1'b0);
    repeat (2) @(negedge clk);
    rec_en = 1'b0;
    repeat (3 * TD) @(negedge clk);
    verify_writes(entry, 2);
    check("t6_len", rec_len, 2);
    check("t6_state", state, 2'b00);
    check("t6_wren_low", ram_wren, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
